// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencing controller: drives the IF stage PC enable and next PC,
// marks fetches valid toward decode, and owns the redirect bubble window and halt/loader handoff.
module fetch_ctrl #(
    parameter int unsigned     PC_W      = 16,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter int unsigned     PC_INC    = 4,
    parameter int unsigned     FLUSH_CYC = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            halt_req,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic [PC_W-1:0] pc,
    output logic            pc_en,
    output logic [PC_W-1:0] next_pc,
    output logic            if_valid,
    output logic            flush,
    input  logic            ld_req,
    output logic            ld_ready,
    output logic            halted,
    output logic [15:0]     fetch_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, HALT} state_t;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYC - 1);

    state_t          state, state_nxt;
    logic [2:0]      flush_cnt, flush_cnt_nxt;
    logic [PC_W-1:0] pc_seq;

    assign pc_seq = pc + PC_W'(PC_INC);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            flush_cnt <= '0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        pc_en         = 1'b0;
        next_pc       = pc_seq;
        if_valid      = 1'b0;
        flush         = 1'b0;
        ld_ready      = 1'b0;
        halted        = 1'b0;

        unique case (state)
            IDLE: begin
                ld_ready = 1'b1;
                next_pc  = RESET_PC;
                if (redirect_valid) begin
                    pc_en   = 1'b1;
                    next_pc = redirect_pc;
                end else if (start && !ld_req) begin
                    pc_en     = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (redirect_valid) begin
                    pc_en         = 1'b1;
                    next_pc       = redirect_pc;
                    flush         = 1'b1;
                    flush_cnt_nxt = FLUSH_LOAD;
                    state_nxt     = FLUSH;
                end else if (halt_req) begin
                    state_nxt = HALT;
                end else begin
                    if_valid = 1'b1;
                    pc_en    = !stall;
                end
            end
            FLUSH: begin
                pc_en = !stall;
                // A redirect inside the window reloads the counter and holds FLUSH even at zero
                if (redirect_valid) begin
                    pc_en         = 1'b1;
                    next_pc       = redirect_pc;
                    flush         = 1'b1;
                    flush_cnt_nxt = FLUSH_LOAD;
                end else if (flush_cnt == '0) begin
                    state_nxt = RUN;
                end else begin
                    flush_cnt_nxt = flush_cnt - 3'd1;
                end
            end
            HALT: begin
                halted   = 1'b1;
                ld_ready = 1'b1;
                if (redirect_valid) begin
                    pc_en   = 1'b1;
                    next_pc = redirect_pc;
                end
                if (!halt_req && !ld_req) state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase

        // Reset overrides the outputs immediately, not just on the following edge
        if (rst) begin
            state_nxt     = IDLE;
            flush_cnt_nxt = '0;
            pc_en         = 1'b0;
            next_pc       = RESET_PC;
            if_valid      = 1'b0;
            flush         = 1'b0;
            ld_ready      = 1'b0;
            halted        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                  fetch_cnt <= '0;
        else if (if_valid && pc_en) fetch_cnt <= fetch_cnt + 16'd1;
    end

endmodule
